writeback_arbiter: RTL and testbench

- Writeback stage directly downstream of the execute units (ALU, multiplier, load-store unit), each of which presents an X__W val/rdy message.
- Round-robin arbitration selects one execute unit per cycle and captures its result into a single-entry writeback register.
- Drains that register to the register-file write port and a commit port in the same handshake.
- Only one destination register write occurs per cycle; unselected units are back-pressured.

---
 rtl/writeback_arbiter.sv | 116 +++++++++++
 tb/tb_writeback_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Writeback stage: round-robin pick of one execute result per cycle
// into a single-entry register drained to the RF write and commit ports.
module writeback_arbiter #(
  parameter int p_num_units    = 4,
  parameter int p_seq_num_bits = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [p_num_units-1:0]                x_val,
  output logic [p_num_units-1:0]                x_rdy,
  input  logic [32*p_num_units-1:0]             x_pc,
  input  logic [p_seq_num_bits*p_num_units-1:0] x_seq_num,
  input  logic [5*p_num_units-1:0]              x_waddr,
  input  logic [32*p_num_units-1:0]             x_wdata,
  input  logic [p_num_units-1:0]                x_wen,
  output logic [4:0]                            rf_waddr,
  output logic [31:0]                           rf_wdata,
  output logic                                  rf_wen,
  output logic                                  commit_val,
  input  logic                                  commit_rdy,
  output logic [31:0]                           commit_pc,
  output logic [p_seq_num_bits-1:0]             commit_seq_num
);

  localparam int PW = $clog2(p_num_units);

  typedef logic [PW-1:0] ptr_t;

  typedef struct packed {
    logic [31:0]               pc;
    logic [p_seq_num_bits-1:0] seq_num;
    logic [4:0]                waddr;
    logic [31:0]               wdata;
    logic                      wen;
  } entry_t;

  entry_t entry_q, entry_d;
  logic   valid_q, valid_d;
  ptr_t   rr_ptr_q, rr_ptr_d;

  logic   free;
  logic   drain;
  logic   take;
  logic   grant_any;
  ptr_t   grant_idx;

  assign drain = valid_q & commit_rdy;
  assign free  = !valid_q | drain;
  assign take  = rst & free & grant_any;

  // Scan units starting at rr_ptr with explicit wrap for any unit count
  always_comb begin
    int j;
    grant_any = 1'b0;
    grant_idx = '0;
    j         = 0;
    for (int k = 0; k < p_num_units; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= p_num_units) j = j - p_num_units;
      if (!grant_any && x_val[j]) begin
        grant_any = 1'b1;
        grant_idx = ptr_t'(j);
      end
    end
  end

  // One-hot ready on the granted unit; implies that unit's valid
  always_comb begin
    x_rdy = '0;
    for (int i = 0; i < p_num_units; i++) begin
      x_rdy[i] = take & (grant_idx == ptr_t'(i));
    end
  end

  // Capture on grant, otherwise clear valid once drained
  always_comb begin
    int gi;
    gi       = int'(grant_idx);
    entry_d  = entry_q;
    valid_d  = valid_q;
    rr_ptr_d = rr_ptr_q;
    if (take) begin
      entry_d.pc      = x_pc[32*gi +: 32];
      entry_d.seq_num = x_seq_num[p_seq_num_bits*gi +: p_seq_num_bits];
      entry_d.waddr   = x_waddr[5*gi +: 5];
      entry_d.wdata   = x_wdata[32*gi +: 32];
      entry_d.wen     = x_wen[gi];
      valid_d         = 1'b1;
      if (gi == p_num_units - 1) rr_ptr_d = '0;
      else                       rr_ptr_d = ptr_t'(grant_idx + 1'b1);
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  // Entry, valid bit and round-robin pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q  <= '0;
      valid_q  <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      entry_q  <= entry_d;
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign commit_val     = valid_q;
  assign commit_pc      = entry_q.pc;
  assign commit_seq_num = entry_q.seq_num;
  assign rf_waddr       = entry_q.waddr;
  assign rf_wdata       = entry_q.wdata;
  assign rf_wen         = drain & entry_q.wen & (entry_q.waddr != 5'd0);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: directed phases
// followed by random valid/commit_rdy traffic.
module tb_writeback_arbiter;

  localparam int N  = 4;
  localparam int SW = 5;

  logic          clk = 0;
  logic          rst = 0;
  logic [N-1:0]  x_val = '0;
  logic [N-1:0]  x_rdy;
  logic [32*N-1:0] x_pc = '0;
  logic [SW*N-1:0] x_seq_num = '0;
  logic [5*N-1:0]  x_waddr = '0;
  logic [32*N-1:0] x_wdata = '0;
  logic [N-1:0]  x_wen = '0;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic          rf_wen;
  logic          commit_val;
  logic          commit_rdy = 0;
  logic [31:0]   commit_pc;
  logic [SW-1:0] commit_seq_num;

  writeback_arbiter #(.p_num_units(N), .p_seq_num_bits(SW)) dut (
    .clk(clk), .rst(rst),
    .x_val(x_val), .x_rdy(x_rdy),
    .x_pc(x_pc), .x_seq_num(x_seq_num),
    .x_waddr(x_waddr), .x_wdata(x_wdata), .x_wen(x_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen),
    .commit_val(commit_val), .commit_rdy(commit_rdy),
    .commit_pc(commit_pc), .commit_seq_num(commit_seq_num)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [SW-1:0] seq;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
    int          unit;
  } exp_t;

  exp_t sb[$];
  int   commit_log[$];
  int   commit_cyc[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ncommit = 0;
  bit mon_en = 0;
  bit m_valid = 0;
  int m_ptr = 0;
  int acc_cnt[N];
  int seen[N];
  int wait_cnt[N];
  int tag = 1000;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic set_unit(input int i, input logic [31:0] pc,
                          input logic [SW-1:0] seq, input logic [4:0] wa,
                          input logic [31:0] wd, input logic we);
    x_pc[32*i +: 32]      = pc;
    x_seq_num[SW*i +: SW] = seq;
    x_waddr[5*i +: 5]     = wa;
    x_wdata[32*i +: 32]   = wd;
    x_wen[i]              = we;
    x_val[i]              = 1'b1;
  endtask

  task automatic wait_acc(input int i);
    int n = 0;
    while (acc_cnt[i] == seen[i] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("acc_timeout", acc_cnt[i] != seen[i], 1);
    seen[i]  = acc_cnt[i];
    x_val[i] = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  // Reference model and scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    int g;
    int j;
    bit free;
    logic [N-1:0] exp_rdy;
    exp_t e;
    if (mon_en && rst) begin
      free = !m_valid || commit_rdy;
      g = -1;
      if (free)
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (g < 0 && x_val[j]) g = j;
        end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("x_rdy", x_rdy, exp_rdy);
      chk("commit_val", commit_val, m_valid);
      if (m_valid) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          e = sb[0];
          chk("commit_pc", commit_pc, e.pc);
          chk("commit_seq", commit_seq_num, e.seq);
          chk("rf_waddr", rf_waddr, e.waddr);
          chk("rf_wdata", rf_wdata, e.wdata);
          chk("rf_wen", rf_wen,
              commit_rdy && e.wen && e.waddr != 5'd0);
          if (commit_rdy) begin
            void'(sb.pop_front());
            commit_log.push_back(e.unit);
            commit_cyc.push_back(cyc);
            ncommit++;
          end
        end
      end else begin
        chk("rf_wen_idle", rf_wen, 0);
      end
      if (g >= 0) begin
        e.pc    = x_pc[32*g +: 32];
        e.seq   = x_seq_num[SW*g +: SW];
        e.waddr = x_waddr[5*g +: 5];
        e.wdata = x_wdata[32*g +: 32];
        e.wen   = x_wen[g];
        e.unit  = g;
        sb.push_back(e);
        chk("starve", wait_cnt[g] < N, 1);
        wait_cnt[g] = 0;
        for (int u = 0; u < N; u++)
          if (u != g && x_val[u]) wait_cnt[u]++;
        acc_cnt[g]++;
        m_valid = 1;
        m_ptr = (g + 1) % N;
      end else if (m_valid && commit_rdy) begin
        m_valid = 0;
      end
    end
  end

  initial begin
    int sent;
    int dly[N];
    int n;
    for (int i = 0; i < N; i++) begin
      acc_cnt[i] = 0; seen[i] = 0; wait_cnt[i] = 0; dly[i] = 0;
    end

    // reset state, with requests present
    x_val = '1;
    commit_rdy = 1;
    repeat (2) @(negedge clk);
    chk("rst_commit_val", commit_val, 0);
    chk("rst_x_rdy", x_rdy, 0);
    chk("rst_rf_wen", rf_wen, 0);
    x_val = '0;
    @(posedge clk); #1;
    rst = 1;
    mon_en = 1;

    // single unit
    @(posedge clk); #1;
    set_unit(1, 32'h200, 5'd3, 5'd5, 32'hDEADBEEF, 1'b1);
    wait_acc(1);
    @(negedge clk);
    chk("single_val", commit_val, 1);
    chk("single_wen", rf_wen, 1);
    chk("single_waddr", rf_waddr, 5);
    chk("single_wdata", rf_wdata, 32'hDEADBEEF);
    chk("single_seq", commit_seq_num, 3);
    chk("single_pc", commit_pc, 32'h200);

    // backpressure
    @(posedge clk); #1;
    commit_rdy = 0;
    set_unit(2, 32'h300, 5'd4, 5'd7, 32'h1234, 1'b1);
    wait_acc(2);
    set_unit(0, 32'h310, 5'd5, 5'd4, 32'h5678, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_val", commit_val, 1);
      chk("bp_rdy", x_rdy, 0);
      chk("bp_wen", rf_wen, 0);
      chk("bp_pc", commit_pc, 32'h300);
    end
    @(posedge clk); #1;
    commit_rdy = 1;
    @(negedge clk);
    chk("bp_release_rdy", x_rdy, 4'b0001);
    chk("bp_release_wen", rf_wen, 1);
    chk("bp_release_waddr", rf_waddr, 7);
    @(posedge clk); #1;
    wait_acc(0);

    // store, then x0 write
    set_unit(3, 32'h400, 5'd6, 5'd9, 32'h55, 1'b0);
    wait_acc(3);
    set_unit(1, 32'h404, 5'd7, 5'd0, 32'h66, 1'b1);
    @(negedge clk);
    chk("store_val", commit_val, 1);
    chk("store_pc", commit_pc, 32'h400);
    chk("store_wen", rf_wen, 0);
    @(posedge clk); #1;
    wait_acc(1);
    @(negedge clk);
    chk("x0_val", commit_val, 1);
    chk("x0_pc", commit_pc, 32'h404);
    chk("x0_wen", rf_wen, 0);

    // async reset while holding an entry
    @(posedge clk); #1;
    commit_rdy = 0;
    set_unit(2, 32'h500, 5'd8, 5'd3, 32'h77, 1'b1);
    wait_acc(2);
    set_unit(0, 32'h504, 5'd9, 5'd2, 32'h88, 1'b1);
    @(negedge clk);
    chk("pre_rst_val", commit_val, 1);
    @(posedge clk); #2;
    mon_en = 0;
    rst = 0;
    #1;
    chk("async_commit_val", commit_val, 0);
    chk("async_x_rdy", x_rdy, 0);
    chk("async_rf_wen", rf_wen, 0);
    m_valid = 0; m_ptr = 0;
    sb.delete();
    for (int i = 0; i < N; i++) begin
      seen[i] = acc_cnt[i]; wait_cnt[i] = 0;
      set_unit(i, 32'h600 + 32'(i*4), SW'(i), 5'(i + 10),
               32'(tag), 1'b1);
      tag++;
    end
    @(negedge clk);
    chk("in_rst_x_rdy", x_rdy, 0);
    @(posedge clk); #1;
    commit_rdy = 1;
    commit_log.delete();
    commit_cyc.delete();
    rst = 1;
    mon_en = 1;
    @(negedge clk);
    chk("post_rst_grant", x_rdy, 4'b0001);

    // round robin with all units continuously valid
    n = 0;
    while (commit_log.size() < 8 && n < 40) begin
      @(posedge clk); #1; n++;
      for (int i = 0; i < N; i++)
        if (acc_cnt[i] != seen[i]) begin
          seen[i] = acc_cnt[i];
          set_unit(i, 32'h700 + 32'(i*4), SW'(i), 5'(i + 10),
                   32'(tag), 1'b1);
          tag++;
        end
    end
    chk("rr_count", commit_log.size() >= 8, 1);
    for (int k = 0; k < 8 && k < commit_log.size(); k++) begin
      chk("rr_unit", commit_log[k], k % N);
      chk("rr_gap", commit_cyc[k] - commit_cyc[0], k);
    end
    x_val = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      seen[i] = acc_cnt[i]; wait_cnt[i] = 0;
    end

    // random traffic
    sent = 0;
    n = ncommit;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      commit_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (x_val[i] && acc_cnt[i] != seen[i]) begin
          seen[i] = acc_cnt[i];
          x_val[i] = 1'b0;
          dly[i] = $urandom_range(0, 3);
        end
        if (!x_val[i]) begin
          if (dly[i] == 0) begin
            if (sent < 200) begin
              set_unit(i, $urandom, SW'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)), 32'(tag),
                       1'($urandom_range(0, 1)));
              tag++;
              sent++;
            end
          end else begin
            dly[i]--;
          end
        end
      end
      if (sent == 200 && x_val == '0 && sb.size() == 0 && !m_valid)
        break;
    end
    chk("rand_sent", sent, 200);
    chk("rand_commits", ncommit - n, 200);
    chk("rand_sb_empty", sb.size(), 0);

    x_val = '0;
    commit_rdy = 1;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
